// File: rtl/smi_req_type_router.sv
// smi_req_type_router
//   Routes SMI request frames to a read or write output by the frame type
//   byte (byte 0 of the first flit). Frames of any other type are consumed
//   and counted in a saturating drop counter. Each output has a 2-entry
//   buffer so frames stream at one flit per clock.
//
// Ports
//   clk, srst                       clock, synchronous active-low reset
//   smiReq{Ready,Eofc,Data,Stop}    upstream request stream
//   smiRdReq{Ready,Eofc,Data,Stop}  read-request output stream
//   smiWrReq{Ready,Eofc,Data,Stop}  write-request output stream
//   dropCount                       discarded frame count, saturates at 255

// 2-entry FIFO used as the per-output buffer.
//   push_i        write din_i (caller guarantees not full)
//   stop_i        downstream backpressure; pop = ready_o & ~stop_i
//   ready_o       FIFO not empty; dout_o is the head entry
//   full_o        registered occupancy == 2 (a same-cycle pop does not clear it)
module smi_req_type_router_fifo #(
  parameter int W = 136
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         stop_i,
  output logic         ready_o,
  output logic [W-1:0] dout_o,
  output logic         full_o
);

  logic [W-1:0] mem_q [2];
  logic         wptr_q, rptr_q;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;

  assign ready_o = (cnt_q != 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign dout_o  = mem_q[rptr_q];
  assign pop     = ready_o & ~stop_i;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srst) begin
      cnt_q  <= 2'd0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push_i) wptr_q <= ~wptr_q;
      if (pop)    rptr_q <= ~rptr_q;
    end
  end

  // Storage needs no reset: occupancy gates what is visible.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= din_i;
  end

endmodule

// State table
//   state        | meaning
//   ST_HEAD      | waiting for first flit of a frame; decode type byte
//   ST_ROUTE_RD  | mid-frame, forwarding flits to the read output
//   ST_ROUTE_WR  | mid-frame, forwarding flits to the write output
//   ST_DISCARD   | mid-frame of an unknown type; flits are dropped
module smi_req_type_router #(
  parameter int         DataIndexSize = 4,
  parameter logic [7:0] ReadReqId     = 8'h01,
  parameter logic [7:0] WriteReqId    = 8'h02,
  localparam int        DataWidth     = (1 << DataIndexSize) * 8
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 smiReqReady,
  input  logic [7:0]           smiReqEofc,
  input  logic [DataWidth-1:0] smiReqData,
  output logic                 smiReqStop,
  output logic                 smiRdReqReady,
  output logic [7:0]           smiRdReqEofc,
  output logic [DataWidth-1:0] smiRdReqData,
  input  logic                 smiRdReqStop,
  output logic                 smiWrReqReady,
  output logic [7:0]           smiWrReqEofc,
  output logic [DataWidth-1:0] smiWrReqData,
  input  logic                 smiWrReqStop,
  output logic [7:0]           dropCount
);

  typedef enum logic [1:0] {
    ST_HEAD     = 2'd0,
    ST_ROUTE_RD = 2'd1,
    ST_ROUTE_WR = 2'd2,
    ST_DISCARD  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] drop_q, drop_d;

  logic rd_full, wr_full;
  logic route_rd, route_wr, discard;
  logic accept, last_flit;
  logic push_rd, push_wr, drop_inc;

  // State register and drop counter
  always_ff @(posedge clk) begin
    if (!srst) begin
      state_q <= ST_HEAD;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (last_flit) begin
        state_d = ST_HEAD;
      end else if (state_q == ST_HEAD) begin
        if (route_rd)      state_d = ST_ROUTE_RD;
        else if (route_wr) state_d = ST_ROUTE_WR;
        else               state_d = ST_DISCARD;
      end
    end
  end

  // Output logic. Stop depends only on registered FIFO fullness, so there is
  // no combinational path from the downstream stops to smiReqStop.
  always_comb begin
    route_rd = 1'b0;
    route_wr = 1'b0;
    discard  = 1'b0;
    case (state_q)
      ST_HEAD: begin
        if (smiReqData[7:0] == ReadReqId)       route_rd = 1'b1;
        else if (smiReqData[7:0] == WriteReqId) route_wr = 1'b1;
        else                                    discard  = 1'b1;
      end
      ST_ROUTE_RD: route_rd = 1'b1;
      ST_ROUTE_WR: route_wr = 1'b1;
      default:     discard  = 1'b1;
    endcase

    smiReqStop = ~srst | (route_rd & rd_full) | (route_wr & wr_full);
    accept     = smiReqReady & ~smiReqStop;
    last_flit  = (smiReqEofc != 8'd0);
    push_rd    = accept & route_rd;
    push_wr    = accept & route_wr;
    drop_inc   = accept & last_flit & discard;
    drop_d     = (drop_inc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  assign dropCount = drop_q;

  smi_req_type_router_fifo #(.W(DataWidth + 8)) u_rd_fifo (
    .clk     (clk),
    .srst    (srst),
    .push_i  (push_rd),
    .din_i   ({smiReqEofc, smiReqData}),
    .stop_i  (smiRdReqStop),
    .ready_o (smiRdReqReady),
    .dout_o  ({smiRdReqEofc, smiRdReqData}),
    .full_o  (rd_full)
  );

  smi_req_type_router_fifo #(.W(DataWidth + 8)) u_wr_fifo (
    .clk     (clk),
    .srst    (srst),
    .push_i  (push_wr),
    .din_i   ({smiReqEofc, smiReqData}),
    .stop_i  (smiWrReqStop),
    .ready_o (smiWrReqReady),
    .dout_o  ({smiWrReqEofc, smiWrReqData}),
    .full_o  (wr_full)
  );

endmodule

// File: tb/tb_smi_req_type_router.sv
module tb_smi_req_type_router;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          srst;
  logic          smiReqReady;
  logic [7:0]    smiReqEofc;
  logic [DW-1:0] smiReqData;
  logic          smiReqStop;
  logic          smiRdReqReady;
  logic [7:0]    smiRdReqEofc;
  logic [DW-1:0] smiRdReqData;
  logic          smiRdReqStop;
  logic          smiWrReqReady;
  logic [7:0]    smiWrReqEofc;
  logic [DW-1:0] smiWrReqData;
  logic          smiWrReqStop;
  logic [7:0]    dropCount;

  always #5 clk = ~clk;

  smi_req_type_router dut (
    .clk           (clk),
    .srst          (srst),
    .smiReqReady   (smiReqReady),
    .smiReqEofc    (smiReqEofc),
    .smiReqData    (smiReqData),
    .smiReqStop    (smiReqStop),
    .smiRdReqReady (smiRdReqReady),
    .smiRdReqEofc  (smiRdReqEofc),
    .smiRdReqData  (smiRdReqData),
    .smiRdReqStop  (smiRdReqStop),
    .smiWrReqReady (smiWrReqReady),
    .smiWrReqEofc  (smiWrReqEofc),
    .smiWrReqData  (smiWrReqData),
    .smiWrReqStop  (smiWrReqStop),
    .dropCount     (dropCount)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: flits accepted but not yet delivered, per output,
  // the destination of the frame in progress (0 = between frames,
  // 1 = read, 2 = write, 3 = dropped) and the number of dropped frames.
  logic [135:0] q_rd[$];
  logic [135:0] q_wr[$];
  int mdest   = 0;
  int mdrop   = 0;
  int rd_deliv = 0;
  int wr_deliv = 0;
  int acc_cnt  = 0;
  bit rand_bp  = 1'b0;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s observed=timeout expected=completion", tag);
  endtask

  function automatic int dest_of(input logic [7:0] b);
    if (b == 8'h01) return 1;
    if (b == 8'h02) return 2;
    return 3;
  endfunction

  function automatic logic [DW-1:0] mk(input logic [7:0] b0);
    logic [DW-1:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    v[7:0] = b0;
    return v;
  endfunction

  // One clock cycle: called at a negedge with inputs already driven.
  task automatic cycle(output bit accepted);
    int d;
    bit stop_exp;
    if (rand_bp) begin
      smiRdReqStop = ($urandom_range(0, 2) == 0);
      smiWrReqStop = ($urandom_range(0, 2) == 0);
    end
    #1;
    d = (mdest == 0) ? dest_of(smiReqData[7:0]) : mdest;
    stop_exp = !srst || (d == 1 && q_rd.size() >= 2) || (d == 2 && q_wr.size() >= 2);
    chk("in_stop", smiReqStop, stop_exp);
    chk("rd_ready", smiRdReqReady, q_rd.size() != 0);
    chk("wr_ready", smiWrReqReady, q_wr.size() != 0);
    chk("drop_count", dropCount, mdrop);
    if (smiRdReqReady === 1'b1 && smiRdReqStop === 1'b0 && q_rd.size() > 0) begin
      chk("rd_flit", {smiRdReqEofc, smiRdReqData}, q_rd[0]);
      void'(q_rd.pop_front());
      rd_deliv++;
    end
    if (smiWrReqReady === 1'b1 && smiWrReqStop === 1'b0 && q_wr.size() > 0) begin
      chk("wr_flit", {smiWrReqEofc, smiWrReqData}, q_wr[0]);
      void'(q_wr.pop_front());
      wr_deliv++;
    end
    accepted = srst && smiReqReady && !stop_exp;
    if (accepted) begin
      if (d == 1) q_rd.push_back({smiReqEofc, smiReqData});
      else if (d == 2) q_wr.push_back({smiReqEofc, smiReqData});
      if (smiReqEofc != 8'd0) begin
        if (d == 3 && mdrop < 255) mdrop++;
        mdest = 0;
      end else begin
        mdest = d;
      end
      acc_cnt++;
    end
    @(posedge clk);
    if (!srst) begin
      q_rd.delete();
      q_wr.delete();
      mdest = 0;
      mdrop = 0;
    end
    @(negedge clk);
  endtask

  task automatic send_flit(input logic [7:0] e, input logic [DW-1:0] d);
    bit a;
    int n;
    smiReqReady = 1'b1;
    smiReqEofc  = e;
    smiReqData  = d;
    n = 0;
    a = 1'b0;
    while (!a && n < 300) begin
      cycle(a);
      n++;
    end
    if (!a) timeout("send_flit");
  endtask

  task automatic idle(input int n);
    bit a;
    smiReqReady = 1'b0;
    repeat (n) cycle(a);
  endtask

  task automatic drain();
    bit a;
    int n;
    smiReqReady = 1'b0;
    n = 0;
    while ((q_rd.size() != 0 || q_wr.size() != 0) && n < 300) begin
      cycle(a);
      n++;
    end
    if (q_rd.size() != 0 || q_wr.size() != 0) timeout("drain");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_rd, base_wr, base_acc, len, t;
    logic [7:0] b0;
    bit a;

    srst = 1'b0;
    smiReqReady = 1'b0;
    smiReqEofc = 8'd0;
    smiReqData = '0;
    smiRdReqStop = 1'b0;
    smiWrReqStop = 1'b0;
    @(negedge clk);

    // Reset held, then idle
    repeat (3) cycle(a);
    srst = 1'b1;
    idle(2);
    chk("idle_stop", smiReqStop, 1'b0);

    // Read frame, no backpressure
    base_rd = rd_deliv;
    send_flit(8'd0,  mk(8'h01));
    send_flit(8'd0,  mk(8'h33));
    send_flit(8'd16, mk(8'h02));
    idle(3);
    chk("rd_frame_count", rd_deliv - base_rd, 3);
    chk("rd_frame_wr_idle", smiWrReqReady, 1'b0);

    // Write frame under backpressure
    smiWrReqStop = 1'b1;
    base_wr = wr_deliv;
    base_acc = acc_cnt;
    send_flit(8'd0, mk(8'h02));
    send_flit(8'd0, mk(8'h01));
    smiReqEofc = 8'd0;
    smiReqData = mk(8'h55);
    repeat (3) cycle(a);
    chk("wr_bp_accepted", acc_cnt - base_acc, 2);
    chk("wr_bp_stop", smiReqStop, 1'b1);
    smiWrReqStop = 1'b0;
    send_flit(8'd0, smiReqData);
    send_flit(8'd16, mk(8'h77));
    drain();
    chk("wr_bp_count", wr_deliv - base_wr, 4);

    // Unknown type then single-flit read
    base_rd = rd_deliv;
    base_wr = wr_deliv;
    send_flit(8'd0, mk(8'hFE));
    send_flit(8'd9, mk(8'h02));
    send_flit(8'd4, mk(8'h01));
    drain();
    chk("unk_drop", dropCount, 8'd1);
    chk("unk_rd_count", rd_deliv - base_rd, 1);
    chk("unk_wr_count", wr_deliv - base_wr, 0);

    // Read path stalled while a write frame drains
    smiRdReqStop = 1'b1;
    base_rd = rd_deliv;
    base_wr = wr_deliv;
    send_flit(8'd5, mk(8'h01));
    send_flit(8'd6, mk(8'h01));
    send_flit(8'd0, mk(8'h02));
    send_flit(8'd0, mk(8'h01));
    send_flit(8'd9, mk(8'h02));
    idle(3);
    chk("xpath_wr_count", wr_deliv - base_wr, 3);
    chk("xpath_rd_held", smiRdReqReady, 1'b1);
    chk("xpath_rd_none", rd_deliv - base_rd, 0);
    smiRdReqStop = 1'b0;
    drain();
    chk("xpath_rd_count", rd_deliv - base_rd, 2);

    // Drop counter saturation
    for (int i = 0; i < 300; i++) begin
      b0 = 8'h03 + 8'(i % 200);
      send_flit(8'($urandom_range(1, 16)), mk(b0));
    end
    idle(1);
    chk("drop_saturated", dropCount, 8'd255);

    // Mid-frame reset
    smiWrReqStop = 1'b1;
    send_flit(8'd0, mk(8'h02));
    send_flit(8'd0, mk(8'h02));
    smiReqReady = 1'b0;
    srst = 1'b0;
    repeat (2) cycle(a);
    chk("rst_wr_ready", smiWrReqReady, 1'b0);
    chk("rst_rd_ready", smiRdReqReady, 1'b0);
    chk("rst_drop", dropCount, 8'd0);
    srst = 1'b1;
    smiWrReqStop = 1'b0;
    base_rd = rd_deliv;
    base_wr = wr_deliv;
    send_flit(8'd7, mk(8'h01));
    drain();
    chk("post_rst_rd", rd_deliv - base_rd, 1);
    chk("post_rst_wr", wr_deliv - base_wr, 0);

    // Randomized frames with random backpressure
    rand_bp = 1'b1;
    for (int f = 0; f < 60; f++) begin
      t = $urandom_range(0, 3);
      b0 = (t == 0) ? 8'h01 : (t == 1) ? 8'h02 : 8'($urandom());
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        if (k == len - 1) send_flit(8'($urandom_range(1, 16)), (k == 0) ? mk(b0) : mk(8'($urandom())));
        else              send_flit(8'd0, (k == 0) ? mk(b0) : mk(8'($urandom())));
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_bp = 1'b0;
    smiRdReqStop = 1'b0;
    smiWrReqStop = 1'b0;
    drain();
    chk("final_rd_empty", smiRdReqReady, 1'b0);
    chk("final_wr_empty", smiWrReqReady, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
